// File: rtl/pulse_seq_pkg.sv
// Shared types and helpers for the pulse event sequencer.
// Holds the FSM state encoding and the gap-counter width function.
// Combinational definitions only; no latency or backpressure of its own.
package pulse_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    GAP   = 2'b10
  } state_t;

  // Width needed to hold MIN_GAP-1 (the gap counter load value), never below 1 bit.
  function automatic int gap_cnt_w(input int min_gap);
    if (min_gap <= 2) return 1;
    return $clog2(min_gap);
  endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter: holds at all-ones on inc, holds at zero on dec.
// One-cycle update; inc and dec together leave the count unchanged.
// clr resets to zero unless inc is also set, in which case the count becomes 1.
module sat_updown_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         full
);

  assign full = &cnt;

  // Count register; a coincident increment beats clear so no event is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? W'(1) : '0;
    end else if (inc && !dec && !full) begin
      cnt <= cnt + W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/pulse_event_sequencer.sv
// Buffers single-cycle pulses and replays them as sequence-numbered valid/ready events.
// Two edges from an idle pulse to ev_valid; then MIN_GAP forced-idle cycles per event.
// ev_valid holds until accepted; pulses beyond capacity are dropped and flagged.
// Optional macro PULSE_SEQ_DROP_CNT_EN adds the saturating drop_cnt output.
module pulse_event_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int PEND_W  = 4,
  parameter int SEQ_W   = 8,
  parameter int MIN_GAP = 2,
  parameter int DROP_W  = 8
) (
  input  logic              clk_fast,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [SEQ_W-1:0]  ev_seq,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
`ifdef PULSE_SEQ_DROP_CNT_EN
  output logic [DROP_W-1:0] drop_cnt,
`endif
  input  logic              clr_overflow
);

  localparam int GW = gap_cnt_w(MIN_GAP);
  localparam logic [GW-1:0] GAP_LOAD = GW'((MIN_GAP > 0) ? (MIN_GAP - 1) : 0);

  state_t          state, state_nxt;
  logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
  logic [SEQ_W-1:0] seq, seq_nxt;
  logic            hs;
  logic            pend_full;
  logic            drop;
  logic            more_after_hs;

  // ev_valid is a pure decode of the state register, so it has no input path.
  assign ev_valid = (state == ISSUE);
  assign ev_seq   = seq;
  assign hs       = ev_valid & ev_ready;
  // A pulse at full is only lost when no slot is freed on the same edge.
  assign drop     = pulse_in & pend_full & ~hs;
  // Pending will still be non-zero after a handshake this cycle.
  assign more_after_hs = pulse_in || (pending > PEND_W'(1));

  sat_updown_cnt #(.W(PEND_W)) u_pend (
    .clk  (clk_fast),
    .rst  (rst),
    .clr  (1'b0),
    .inc  (pulse_in),
    .dec  (hs),
    .cnt  (pending),
    .full (pend_full)
  );

`ifdef PULSE_SEQ_DROP_CNT_EN
  logic drop_full;
  sat_updown_cnt #(.W(DROP_W)) u_drop (
    .clk  (clk_fast),
    .rst  (rst),
    .clr  (clr_overflow),
    .inc  (drop),
    .dec  (1'b0),
    .cnt  (drop_cnt),
    .full (drop_full)
  );
`endif

  // State, gap counter and sequence number registers.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
      seq     <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
      seq     <= seq_nxt;
    end
  end

  // Next-state logic: offer, bump sequence on accept, then enforce the idle gap.
  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    seq_nxt     = seq;
    case (state)
      IDLE: begin
        if (pending != '0) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (hs) begin
          seq_nxt = seq + SEQ_W'(1);
          if (MIN_GAP > 0) begin
            state_nxt   = GAP;
            gap_cnt_nxt = GAP_LOAD;
          end else if (!more_after_hs) begin
            state_nxt = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = (pending != '0) ? ISSUE : IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - GW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sticky overflow flag; a drop in the clearing cycle keeps it set.
  always_ff @(posedge clk_fast or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule
